// File: rtl/mult_div_module_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mult_div_module_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_module_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu.
// res_valid is low on divide by zero so the caller keeps HI/LO unchanged.
module md_arith_module
  import mult_div_module_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        res_valid
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic [31:0] b_safe;
  logic        div_zero;
  logic        div_ovf;

  always_comb begin
    div_zero = (b == 32'd0);
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // keep the dividers away from the two undefined cases; those results are overridden below
    b_safe   = (div_zero || div_ovf) ? 32'd1 : b;
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'd0, a} * {32'd0, b};
    quo_s    = $signed(a) / $signed(b_safe);
    rem_s    = $signed(a) % $signed(b_safe);
    quo_u    = a / b_safe;
    rem_u    = a % b_safe;

    res       = 64'd0;
    res_valid = 1'b1;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        res_valid = !div_zero;
        res       = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
      end
      default: begin
        res_valid = !div_zero;
        res       = {rem_u, quo_u};
      end
    endcase
  end

endmodule

// File: rtl/mult_div_module.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO.
// FSM: IDLE (accept start/mthi/mtlo) | RUN (count down, write HI/LO at terminal count).
module mult_div_module
  import mult_div_module_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      res;
  logic             res_valid;

  md_arith_module u_arith (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .res       (res),
    .res_valid (res_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = md_op;
          a_d     = A;
          b_d     = B;
          cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_d = ST_RUN;
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      default: begin
        // start/mthi/mtlo are ignored here; the hazard unit holds them off via md_stall
        if (cnt_q == '0) begin
          if (res_valid) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign md_stall = start | busy;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_module.sv
// Self-checking bench for mult_div_module: directed cases plus random ops vs. an arithmetic model.
module tb_mult_div_module;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  md_op;
  logic        mthi, mtlo;
  logic [31:0] A, B;
  logic        busy, md_stall;
  logic [31:0] HI, LO;

  logic [31:0] hi_m, lo_m;
  int          n_tests = 0;
  int          n_fail  = 0;

  mult_div_module #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .md_op    (md_op),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference: HI/LO after an op, from plain integer arithmetic
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    case (op)
      2'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        hi_m = ps[63:32]; lo_m = ps[31:0];
      end
      2'd1: begin
        pu = 64'(a) * 64'(b);
        hi_m = pu[63:32]; lo_m = pu[31:0];
      end
      2'd2: begin
        if (b == 0) begin
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = 32'd0;
        end else begin
          sa = $signed(a); sb = $signed(b);
          lo_m = 32'(sa / sb); hi_m = 32'(sa % sb);
        end
      end
      default: begin
        if (b != 0) begin
          lo_m = a / b; hi_m = a % b;
        end
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic with_mtlo, input logic disturb);
    int n;
    model_op(op, a, b);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b; mtlo = with_mtlo;
    #1 chk({tag, "_stall_start"}, 64'(md_stall), 64'd1);
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (disturb && n == 3) begin
        start = 1'b1; md_op = 2'd0; mthi = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(op[1] ? DIV_N : MULT_N));
    chk({tag, "_hi"}, 64'(HI), 64'(hi_m));
    chk({tag, "_lo"}, 64'(LO), 64'(lo_m));
  endtask

  task automatic move_to(input string tag, input logic h, input logic l, input logic [31:0] a);
    @(negedge clk);
    mthi = h; mtlo = l; A = a;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) hi_m = a;
    if (l) lo_m = a;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(HI), 64'(hi_m));
    chk({tag, "_lo"}, 64'(LO), 64'(lo_m));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; md_op = 2'd0; mthi = 1'b0; mtlo = 1'b0;
    A = 32'd0; B = 32'd0; hi_m = 32'd0; lo_m = 32'd0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_neg_hi_const", 64'(HI), 64'hFFFF_FFFF);
    chk("mult_neg_lo_const", 64'(LO), 64'hFFFF_FFEB);
    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("multu_hi_const", 64'(HI), 64'd1);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg_lo_const", 64'(LO), 64'hFFFF_FFFD);
    chk("div_neg_hi_const", 64'(HI), 64'hFFFF_FFFF);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_lo_const", 64'(LO), 64'h8000_0000);

    move_to("mthi", 1'b1, 1'b0, 32'h1234);
    move_to("mtlo", 1'b0, 1'b1, 32'h5678);
    run_op("divu_zero", 2'd3, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    chk("divu_zero_hi_const", 64'(HI), 64'h1234);
    run_op("div_zero", 2'd2, 32'h0000_0055, 32'd0, 1'b0, 1'b0);
    move_to("mthi_mtlo", 1'b1, 1'b1, 32'hCAFE_F00D);

    run_op("div_disturb", 2'd2, 32'd1000, 32'd7, 1'b0, 1'b1);
    run_op("start_mtlo", 2'd1, 32'd12345, 32'd678, 1'b1, 1'b0);

    // reset during an operation
    @(negedge clk);
    start = 1'b1; md_op = 2'd0; A = 32'd9; B = 32'd9;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(HI), 64'd0);
    chk("rst_mid_lo", 64'(LO), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op("after_rst", 2'd0, 32'd6, 32'hFFFF_FFF9, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] ra, rb;
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 5));
      if ($urandom_range(0, 5) == 0)
        move_to("rnd_mv", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op("rnd", op, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
